// File: rtl/btc_frame_engine_pkg.sv
// Shared definitions for the grayscale + AMBTC frame engine:
// FSM state encoding, mode bit positions and a constant log2 helper.
package btc_frame_engine_pkg;

    typedef enum logic [3:0] {
        IDLE,
        G_ADDR,
        G_WR,
        GRAY_DONE,
        C_SUM_ADDR,
        C_SUM_ACC,
        C_VAR_ADDR,
        C_VAR_ACC,
        C_DIV_L,
        C_DIV_H,
        C_WR_ADDR,
        C_WR,
        C_NEXT,
        C_DONE
    } state_t;

    localparam int MODE_GRAY = 0;
    localparam int MODE_CMP  = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/btc_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Pulse start with operands; done pulses once quotient is valid.
module btc_div #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [DW:0]   shifted;
    logic [DW:0]   trial;

    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = CW'(DW);
            run_d = 1'b1;
        end else if (run_q) begin
            // trial[DW] set means the subtraction went negative
            if (!trial[DW]) begin
                rem_d = trial[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = shifted[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/btc_frame_engine.sv
// Grayscale + AMBTC compression of one frame, read-modify-write
// in place on an external frame buffer.
module btc_frame_engine
    import btc_frame_engine_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int BLK    = 4,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [3*PIX_W-1:0]   in_pix,
    output logic [ADDR_W-1:0]    row,
    output logic [ADDR_W-1:0]    col,
    output logic                 out_we,
    output logic [3*PIX_W-1:0]   out_pix,
    output logic                 busy,
    output logic                 gray_done,
    output logic                 compress_done
);
    localparam int N   = BLK * BLK;
    localparam int K   = clog2(N);
    localparam int KB  = K / 2;
    localparam int SW  = PIX_W + K;
    localparam int QW  = K + 1;
    localparam int DW  = PIX_W + 2 * K + 1;
    localparam int DW1 = DW + 1;
    localparam logic [QW-1:0] N_V = QW'(N);

    state_t            state_q, state_d;
    logic              cmp_q, cmp_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] br_q, br_d, bc_q, bc_d;
    logic [K-1:0]      p_q, p_d;
    logic [SW-1:0]     sum_q, sum_d, var_q, var_d;
    logic [QW-1:0]     cnt1_q, cnt1_d;
    logic [PIX_W-1:0]  avg_q, avg_d, lo_q, lo_d, hi_q, hi_d;
    logic              drun_q, drun_d;

    logic [PIX_W-1:0]  r_px, g_px, b_px;
    logic [PIX_W-1:0]  mn01, mn, mx01, mx, gray;
    logic [PIX_W:0]    gsum;
    logic              g_ge, last_p;
    logic [PIX_W-1:0]  adiff, var_avg, lo_val, hi_val;
    logic [ADDR_W-1:0] pix_row, pix_col;
    logic              div_start, div_done;
    logic [DW-1:0]     dividend, divisor, quot;
    logic [DW:0]       hsum;
    logic [PIX_W-1:0]  zp;

    assign zp   = '0;
    assign r_px = in_pix[3*PIX_W-1:2*PIX_W];
    assign g_px = in_pix[2*PIX_W-1:PIX_W];
    assign b_px = in_pix[PIX_W-1:0];

    assign mn01 = (r_px < g_px) ? r_px : g_px;
    assign mn   = (mn01 < b_px) ? mn01 : b_px;
    assign mx01 = (r_px > g_px) ? r_px : g_px;
    assign mx   = (mx01 > b_px) ? mx01 : b_px;
    assign gsum = {1'b0, mn} + {1'b0, mx};
    assign gray = PIX_W'(gsum >> 1);

    assign g_ge    = (g_px >= avg_q);
    assign adiff   = g_ge ? (g_px - avg_q) : (avg_q - g_px);
    assign last_p  = &p_q;
    assign pix_row = br_q + ADDR_W'(p_q[K-1:KB]);
    assign pix_col = bc_q + ADDR_W'(p_q[KB-1:0]);

    // N*var is var shifted up by K; L uses 2*(N-q), H uses 2*q
    assign var_avg  = var_q[SW-1:K];
    assign dividend = DW'({var_avg, {K{1'b0}}});
    assign divisor  = (state_q == C_DIV_H) ? DW'({cnt1_q, 1'b0})
                                           : DW'({N_V - cnt1_q, 1'b0});

    assign lo_val = (quot > DW'(avg_q)) ? '0 : avg_q - quot[PIX_W-1:0];
    assign hsum   = {1'b0, quot} + DW1'(avg_q);
    assign hi_val = (|hsum[DW:PIX_W]) ? '1 : hsum[PIX_W-1:0];

    btc_div #(.DW(DW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (quot)
    );

    always_comb begin
        state_d       = state_q;
        cmp_d         = cmp_q;
        row_d         = row_q;
        col_d         = col_q;
        br_d          = br_q;
        bc_d          = bc_q;
        p_d           = p_q;
        sum_d         = sum_q;
        var_d         = var_q;
        cnt1_d        = cnt1_q;
        avg_d         = avg_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        drun_d        = drun_q;
        div_start     = 1'b0;
        out_we        = 1'b0;
        out_pix       = '0;
        gray_done     = 1'b0;
        compress_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && (mode != 2'b00)) begin
                    cmp_d   = mode[MODE_CMP];
                    row_d   = '0;
                    col_d   = '0;
                    br_d    = '0;
                    bc_d    = '0;
                    p_d     = '0;
                    sum_d   = '0;
                    var_d   = '0;
                    cnt1_d  = '0;
                    state_d = mode[MODE_GRAY] ? G_ADDR : C_SUM_ADDR;
                end
            end
            G_ADDR: state_d = G_WR;
            G_WR: begin
                out_we  = 1'b1;
                out_pix = {zp, gray, zp};
                state_d = G_ADDR;
                if (col_q == ADDR_W'(IMG_W - 1)) begin
                    col_d = '0;
                    if (row_q == ADDR_W'(IMG_H - 1)) begin
                        row_d   = '0;
                        state_d = GRAY_DONE;
                    end else begin
                        row_d = row_q + ADDR_W'(1);
                    end
                end else begin
                    col_d = col_q + ADDR_W'(1);
                end
            end
            GRAY_DONE: begin
                gray_done = 1'b1;
                state_d   = cmp_q ? C_SUM_ADDR : IDLE;
            end
            C_SUM_ADDR: begin
                row_d   = pix_row;
                col_d   = pix_col;
                state_d = C_SUM_ACC;
            end
            C_SUM_ACC: begin
                sum_d   = sum_q + SW'(g_px);
                p_d     = p_q + K'(1);
                state_d = C_SUM_ADDR;
                if (last_p) begin
                    avg_d   = sum_d[SW-1:K];
                    state_d = C_VAR_ADDR;
                end
            end
            C_VAR_ADDR: begin
                row_d   = pix_row;
                col_d   = pix_col;
                state_d = C_VAR_ACC;
            end
            C_VAR_ACC: begin
                var_d   = var_q + SW'(adiff);
                p_d     = p_q + K'(1);
                state_d = last_p ? C_DIV_L : C_VAR_ADDR;
                if (g_ge) cnt1_d = cnt1_q + QW'(1);
            end
            C_DIV_L: begin
                if (cnt1_q == N_V) begin
                    lo_d    = avg_q;
                    hi_d    = avg_q;
                    state_d = C_WR_ADDR;
                end else if (!drun_q) begin
                    div_start = 1'b1;
                    drun_d    = 1'b1;
                end else if (div_done) begin
                    drun_d  = 1'b0;
                    lo_d    = lo_val;
                    state_d = C_DIV_H;
                end
            end
            C_DIV_H: begin
                if (!drun_q) begin
                    div_start = 1'b1;
                    drun_d    = 1'b1;
                end else if (div_done) begin
                    drun_d  = 1'b0;
                    hi_d    = hi_val;
                    state_d = C_WR_ADDR;
                end
            end
            C_WR_ADDR: begin
                row_d   = pix_row;
                col_d   = pix_col;
                state_d = C_WR;
            end
            C_WR: begin
                out_we  = 1'b1;
                out_pix = {zp, (g_ge ? hi_q : lo_q), zp};
                p_d     = p_q + K'(1);
                state_d = last_p ? C_NEXT : C_WR_ADDR;
            end
            C_NEXT: begin
                sum_d   = '0;
                var_d   = '0;
                cnt1_d  = '0;
                state_d = C_SUM_ADDR;
                if (bc_q == ADDR_W'(IMG_W - BLK)) begin
                    bc_d = '0;
                    if (br_q == ADDR_W'(IMG_H - BLK)) begin
                        br_d    = '0;
                        state_d = C_DONE;
                    end else begin
                        br_d = br_q + ADDR_W'(BLK);
                    end
                end else begin
                    bc_d = bc_q + ADDR_W'(BLK);
                end
            end
            C_DONE: begin
                compress_done = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmp_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            br_q    <= '0;
            bc_q    <= '0;
            p_q     <= '0;
            sum_q   <= '0;
            var_q   <= '0;
            cnt1_q  <= '0;
            avg_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            drun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            row_q   <= row_d;
            col_q   <= col_d;
            br_q    <= br_d;
            bc_q    <= bc_d;
            p_q     <= p_d;
            sum_q   <= sum_d;
            var_q   <= var_d;
            cnt1_q  <= cnt1_d;
            avg_q   <= avg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            drun_q  <= drun_d;
        end
    end

    // busy already drops in the cycle of the final done pulse
    assign busy = (state_q != IDLE) && (state_q != C_DONE) &&
                  !((state_q == GRAY_DONE) && !cmp_q);
    assign row  = row_q;
    assign col  = col_q;

endmodule

// File: tb/tb_btc_frame_engine.sv
// Bench for btc_frame_engine: a 64x64/BLK4 and an 8x8/BLK2 instance,
// each on its own frame buffer, checked against an arithmetic model.
module tb_btc_frame_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, cp_a, cp_b;
    logic [1:0]  mode;
    logic [23:0] in_a, pix_a, in_b, pix_b;
    logic [5:0]  row_a, col_a;
    logic [2:0]  row_b, col_b;
    logic        we_a, busy_a, gd_a, cd_a;
    logic        we_b, busy_b, gd_b, cd_b;
    logic [23:0] fba [0:4095];
    logic [23:0] fbb [0:63];
    logic [23:0] mdl [0:4095];
    int          sel;
    int          total, bad;
    int          r_gdc, r_cdc, r_ngd, r_ncd, r_nwr, r_nx;
    int          r_busy1, r_tmo, r_post;

    btc_frame_engine dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
        .in_pix(in_a), .row(row_a), .col(col_a), .out_we(we_a),
        .out_pix(pix_a), .busy(busy_a), .gray_done(gd_a),
        .compress_done(cd_a)
    );

    btc_frame_engine #(
        .IMG_W(8), .IMG_H(8), .BLK(2), .PIX_W(8), .ADDR_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
        .in_pix(in_b), .row(row_b), .col(col_b), .out_we(we_b),
        .out_pix(pix_b), .busy(busy_b), .gray_done(gd_b),
        .compress_done(cd_b)
    );

    assign in_a = fba[{row_a, col_a}];
    assign in_b = fbb[{row_b, col_b}];

    always @(posedge clk) begin
        if (cp_a) for (int i = 0; i < 4096; i++) fba[i] <= mdl[i];
        else if (we_a) fba[{row_a, col_a}] <= pix_a;
    end

    always @(posedge clk) begin
        if (cp_b) for (int i = 0; i < 64; i++) fbb[i] <= mdl[i];
        else if (we_b) fbb[{row_b, col_b}] <= pix_b;
    end

    logic        s_busy, s_we, s_gd, s_cd;
    logic [23:0] s_pix;
    assign s_busy = (sel == 0) ? busy_a : busy_b;
    assign s_we   = (sel == 0) ? we_a : we_b;
    assign s_gd   = (sel == 0) ? gd_a : gd_b;
    assign s_cd   = (sel == 0) ? cd_a : cd_b;
    assign s_pix  = (sel == 0) ? pix_a : pix_b;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) mdl[i] = 24'($urandom);
    endtask

    task automatic load(input int s);
        @(negedge clk);
        if (s == 0) cp_a = 1'b1;
        else cp_b = 1'b1;
        @(negedge clk);
        cp_a = 1'b0;
        cp_b = 1'b0;
    endtask

    task automatic mdl_gray(input int w, input int h);
        int r, g, b, mn, mx;
        for (int i = 0; i < w * h; i++) begin
            r = int'(mdl[i][23:16]);
            g = int'(mdl[i][15:8]);
            b = int'(mdl[i][7:0]);
            mn = (r < g) ? r : g;
            mn = (mn < b) ? mn : b;
            mx = (r > g) ? r : g;
            mx = (mx > b) ? mx : b;
            mdl[i] = {8'd0, 8'((mn + mx) / 2), 8'd0};
        end
    endtask

    task automatic mdl_btc(input int w, input int h, input int bs);
        int n, k, sum, avg, v, q, lo, hi, g, idx;
        n = bs * bs;
        k = $clog2(n);
        for (int br = 0; br < h; br += bs) begin
            for (int bc = 0; bc < w; bc += bs) begin
                sum = 0;
                v = 0;
                q = 0;
                for (int i = 0; i < n; i++)
                    sum += int'(mdl[(br + i / bs) * w + bc + i % bs][15:8]);
                avg = sum / n;
                for (int i = 0; i < n; i++) begin
                    g = int'(mdl[(br + i / bs) * w + bc + i % bs][15:8]);
                    v += (g >= avg) ? g - avg : avg - g;
                    if (g >= avg) q++;
                end
                v = v >> k;
                if (q == n) begin
                    lo = avg;
                    hi = avg;
                end else begin
                    lo = avg - (n * v) / (2 * (n - q));
                    hi = avg + (n * v) / (2 * q);
                end
                if (lo < 0) lo = 0;
                if (hi > 255) hi = 255;
                for (int i = 0; i < n; i++) begin
                    idx = (br + i / bs) * w + bc + i % bs;
                    g = int'(mdl[idx][15:8]);
                    mdl[idx] = {8'd0, 8'((g >= avg) ? hi : lo), 8'd0};
                end
            end
        end
    endtask

    task automatic cmp_frame(input string tag, input int s, input int n);
        int d;
        d = 0;
        for (int i = 0; i < n; i++) begin
            if (s == 0) begin
                if (fba[i] !== mdl[i]) d++;
            end else begin
                if (fbb[i] !== mdl[i]) d++;
            end
        end
        chk(tag, d, 0);
    endtask

    task automatic run(input int s, input logic [1:0] md, input int p1,
                       input int p2, input int lim);
        int cyc;
        sel = s;
        r_gdc = 0; r_cdc = 0; r_ngd = 0; r_ncd = 0; r_nwr = 0;
        r_nx = 0; r_busy1 = 0; r_tmo = 0; r_post = 0;
        @(negedge clk);
        mode = md;
        if (s == 0) start_a = 1'b1;
        else start_b = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            mode = 2'b11;
            if (cyc == 1) r_busy1 = int'(s_busy);
            if (s_gd) begin r_ngd++; r_gdc = cyc; end
            if (s_cd) begin r_ncd++; r_cdc = cyc; end
            if (s_we) r_nwr++;
            if (s_we && $isunknown(s_pix)) r_nx++;
            if (cyc == p1 || cyc == p2) begin
                if (s == 0) start_a = 1'b1;
                else start_b = 1'b1;
            end
        end while (s_busy && cyc < lim);
        if (s_busy) r_tmo = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (s_busy || s_we || s_gd || s_cd) r_post++;
        end
    endtask

    initial begin
        int nwr, nu;
        total = 0; bad = 0; sel = 0;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        cp_a = 1'b0; cp_b = 1'b0; mode = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_row", row_a, 0);
        chk("rst_col", col_a, 0);
        chk("rst_we", we_a, 0);
        chk("rst_pix", pix_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", {gd_a, cd_a, gd_b, cd_b, busy_b}, 0);
        rst_n = 1'b1;

        fill(4096);
        mdl[5] = 24'hC86432;
        load(0);
        run(0, 2'b01, 0, 0, 10000);
        mdl_gray(64, 64);
        chk("a_gray_tmo", r_tmo, 0);
        chk("a_gray_busy1", r_busy1, 1);
        chk("a_gray_ngd", r_ngd, 1);
        chk("a_gray_cyc", r_gdc, 2 * 64 * 64 + 1);
        chk("a_gray_ncd", r_ncd, 0);
        chk("a_gray_nwr", r_nwr, 4096);
        chk("a_gray_px", fba[5], 24'h007D00);
        chk("a_gray_post", r_post, 0);
        cmp_frame("a_gray_frame", 0, 4096);

        fill(4096);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                mdl[r * 64 + c][15:8] = (r < 2) ? 8'd10 : 8'd30;
                mdl[r * 64 + 4 + c][15:8] = 8'd77;
            end
        end
        load(0);
        run(0, 2'b10, 0, 0, 60000);
        mdl_btc(64, 64, 4);
        chk("a_btc_tmo", r_tmo, 0);
        chk("a_btc_ngd", r_ngd, 0);
        chk("a_btc_ncd", r_ncd, 1);
        chk("a_btc_nwr", r_nwr, 4096);
        chk("a_btc_nox", r_nx, 0);
        chk("a_btc_lo", fba[0], 24'h000A00);
        chk("a_btc_hi", fba[2 * 64 + 3], 24'h001E00);
        nu = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 4; c < 8; c++)
                if (fba[r * 64 + c] !== 24'h004D00) nu++;
        chk("a_btc_uniform", nu, 0);
        cmp_frame("a_btc_frame", 0, 4096);

        fill(64);
        load(1);
        run(1, 2'b11, 0, 0, 5000);
        mdl_gray(8, 8);
        mdl_btc(8, 8, 2);
        chk("b_both_tmo", r_tmo, 0);
        chk("b_both_ngd", r_ngd, 1);
        chk("b_both_gcyc", r_gdc, 129);
        chk("b_both_ncd", r_ncd, 1);
        chk("b_both_order", r_cdc > r_gdc, 1);
        chk("b_both_nwr", r_nwr, 128);
        chk("b_both_post", r_post, 0);
        cmp_frame("b_both_frame", 1, 64);

        fill(64);
        load(1);
        sel = 1;
        @(negedge clk);
        mode = 2'b10;
        start_b = 1'b1;
        nwr = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (we_b) nwr++;
        end
        chk("b_var_busy", busy_b, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("b_rst_outs", {row_b, col_b, we_b, pix_b, gd_b, cd_b}, 0);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_prewr", nwr, 0);
        rst_n = 1'b1;
        mdl_btc(8, 8, 2);
        run(1, 2'b10, 0, 0, 5000);
        chk("b_restart_tmo", r_tmo, 0);
        chk("b_restart_ncd", r_ncd, 1);
        chk("b_restart_nwr", r_nwr, 64);
        cmp_frame("b_restart_frame", 1, 64);

        run(1, 2'b00, 0, 0, 50);
        chk("b_m00_busy", r_busy1, 0);
        chk("b_m00_act", r_ngd + r_ncd + r_nwr, 0);
        chk("b_m00_post", r_post, 0);

        fill(64);
        load(1);
        run(1, 2'b01, 40, 129, 1000);
        mdl_gray(8, 8);
        chk("b_ign_ngd", r_ngd, 1);
        chk("b_ign_gcyc", r_gdc, 129);
        chk("b_ign_ncd", r_ncd, 0);
        chk("b_ign_nwr", r_nwr, 64);
        chk("b_ign_post", r_post, 0);
        cmp_frame("b_ign_frame", 1, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
